// File: rtl/column_drain_collector.sv
// column_drain_collector: accumulates a programmable number of column partial
// sums per output pixel with signed saturation, buffers the finished results
// in a first-word-fall-through FIFO and drains them over valid/ready.
module column_drain_collector #(
  parameter int F_WIDTH        = 8,
  parameter int I_WIDTH        = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int PASS_CNT_WIDTH = 4,
  parameter int OUT_CNT_WIDTH  = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              start_i,
  input  logic [PASS_CNT_WIDTH-1:0]         num_pass_i,
  input  logic [OUT_CNT_WIDTH-1:0]          num_out_i,
  input  logic signed [I_WIDTH+F_WIDTH-1:0] node_data_i,
  input  logic                              node_c_i,
  input  logic                              node_valid_i,
  output logic                              stall_o,
  output logic signed [I_WIDTH+F_WIDTH-1:0] out_data_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              sat_o,
  output logic                              carry_o
);

  localparam int W  = I_WIDTH + F_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state;
  logic [PASS_CNT_WIDTH-1:0]  pass_total;
  logic [PASS_CNT_WIDTH-1:0]  pass_cnt;
  logic [OUT_CNT_WIDTH-1:0]   out_total;
  logic [OUT_CNT_WIDTH-1:0]   out_cnt;
  logic signed [W-1:0]        acc;

  logic [W-1:0]               mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [AW:0]                count;

  logic                       full;
  logic                       empty;
  logic                       accept;
  logic                       last_pass;
  logic                       last_out;
  logic                       push;
  logic                       pop;
  logic signed [W:0]          sum_wide;
  logic                       sat_hit;
  logic signed [W-1:0]        sat_sum;

  // Handshake decode and the one-bit-wider saturating add
  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    accept    = (state == ACCUM) && node_valid_i && !full;
    last_pass = (pass_cnt == pass_total - PASS_CNT_WIDTH'(1));
    last_out  = (out_cnt == out_total - OUT_CNT_WIDTH'(1));
    push      = accept && last_pass;
    pop       = !empty && out_ready_i;
    sum_wide  = {acc[W-1], acc} + {node_data_i[W-1], node_data_i};
    // The extra top bit disagrees with the sign bit only on overflow
    sat_hit   = sum_wide[W] ^ sum_wide[W-1];
    if (!sat_hit) begin
      sat_sum = sum_wide[W-1:0];
    end else if (sum_wide[W]) begin
      sat_sum = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_sum = {1'b0, {(W-1){1'b1}}};
    end
  end

  assign stall_o     = full;
  assign out_valid_o = !empty;
  assign out_data_o  = empty ? '0 : mem[rd_ptr];
  assign busy_o      = (state == ACCUM);

  // Group sequencing: pass/result counters, accumulator and sticky flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      pass_total <= '0;
      pass_cnt   <= '0;
      out_total  <= '0;
      out_cnt    <= '0;
      acc        <= '0;
      done_o     <= 1'b0;
      sat_o      <= 1'b0;
      carry_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            // A zero count would never complete, so it means one
            pass_total <= (num_pass_i == '0) ? PASS_CNT_WIDTH'(1) : num_pass_i;
            out_total  <= (num_out_i == '0) ? OUT_CNT_WIDTH'(1) : num_out_i;
            pass_cnt   <= '0;
            out_cnt    <= '0;
            acc        <= '0;
            sat_o      <= 1'b0;
            carry_o    <= 1'b0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sat_hit) sat_o <= 1'b1;
            if (node_c_i) carry_o <= 1'b1;
            if (last_pass) begin
              acc      <= '0;
              pass_cnt <= '0;
              out_cnt  <= out_cnt + OUT_CNT_WIDTH'(1);
              if (last_out) begin
                state  <= IDLE;
                done_o <= 1'b1;
              end
            end else begin
              acc      <= sat_sum;
              pass_cnt <= pass_cnt + PASS_CNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Result storage; contents need no reset because the output is gated by empty
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= sat_sum;
  end

endmodule

// File: tb/tb_column_drain_collector.sv
// Testbench for column_drain_collector: table-driven basic group, hand-written
// corner sequences and randomized groups against a queue-based reference model.
module tb_column_drain_collector;

  localparam int W = 16;
  localparam int D = 8;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  logic                start_i = 1'b0;
  logic [3:0]          num_pass_i = '0;
  logic [7:0]          num_out_i = '0;
  logic signed [W-1:0] node_data_i = '0;
  logic                node_c_i = 1'b0;
  logic                node_valid_i = 1'b0;
  logic                stall_o;
  logic signed [W-1:0] out_data_o;
  logic                out_valid_o;
  logic                out_ready_i = 1'b0;
  logic                busy_o;
  logic                done_o;
  logic                sat_o;
  logic                carry_o;

  column_drain_collector dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .num_pass_i(num_pass_i), .num_out_i(num_out_i),
    .node_data_i(node_data_i), .node_c_i(node_c_i), .node_valid_i(node_valid_i),
    .stall_o(stall_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o),
    .sat_o(sat_o), .carry_o(carry_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Reference model: group bookkeeping in plain integers, FIFO as a queue
  bit m_busy, m_done, m_sat, m_carry;
  int m_acc, m_pass, m_P, m_N, m_oc;
  int q[$];
  int popped[$];
  int done_count;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_sat = 0; m_carry = 0;
    m_acc = 0; m_pass = 0; m_P = 1; m_N = 1; m_oc = 0;
    q.delete();
  endtask

  task automatic model_edge(input bit st, input int np, input int no,
                            input bit v, input int d, input bit c, input bit rdy);
    bit pop, full, push;
    int s;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == D);
    push = 0;
    s    = 0;
    m_done = 0;
    if (!m_busy) begin
      if (st) begin
        m_P = (np == 0) ? 1 : np;
        m_N = (no == 0) ? 1 : no;
        m_acc = 0; m_pass = 0; m_oc = 0; m_sat = 0; m_carry = 0;
        m_busy = 1;
      end
    end else if (v && !full) begin
      s = m_acc + d;
      if (s > MAXV) begin s = MAXV; m_sat = 1; end
      else if (s < MINV) begin s = MINV; m_sat = 1; end
      if (c) m_carry = 1;
      if (m_pass == m_P - 1) begin
        push = 1; m_acc = 0; m_pass = 0; m_oc++;
        if (m_oc == m_N) begin m_busy = 0; m_done = 1; end
      end else begin
        m_acc = s; m_pass++;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(s);
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge
  task automatic step(input bit st, input int np, input int no,
                      input bit v, input int d, input bit c, input bit rdy);
    start_i = st; num_pass_i = np[3:0]; num_out_i = no[7:0];
    node_valid_i = v; node_data_i = d[W-1:0]; node_c_i = c; out_ready_i = rdy;
    if (out_valid_o && rdy) popped.push_back(int'(out_data_o));
    @(posedge clk_i);
    model_edge(st, np, no, v, d, c, rdy);
    @(negedge clk_i);
    if (done_o) done_count++;
    chk("out_valid", int'(out_valid_o), int'(q.size() > 0));
    chk("out_data", int'(out_data_o), (q.size() > 0) ? q[0] : 0);
    chk("stall", int'(stall_o), int'(q.size() == D));
    chk("busy", int'(busy_o), int'(m_busy));
    chk("done", int'(done_o), int'(m_done));
    chk("sat", int'(sat_o), int'(m_sat));
    chk("carry", int'(carry_o), int'(m_carry));
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    start_i = 0; node_valid_i = 0; out_ready_i = 0;
    #1;
    model_reset();
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_out_data", int'(out_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_sat", int'(sat_o), 0);
    chk("rst_carry", int'(carry_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  typedef struct {
    bit st; int np; int no; bit v; int d; bit rdy;
    bit e_ov; int e_data; bit e_busy; bit e_done; bit e_sat;
  } vec_t;

  vec_t basic[8];

  initial begin
    int cyc;
    int exp_seq[$];
    basic[0] = '{1, 3, 2, 0,   0, 1, 0,   0, 1, 0, 0};
    basic[1] = '{0, 0, 0, 1,  10, 1, 0,   0, 1, 0, 0};
    basic[2] = '{0, 0, 0, 1,  20, 1, 0,   0, 1, 0, 0};
    basic[3] = '{0, 0, 0, 1,  30, 1, 1,  60, 1, 0, 0};
    basic[4] = '{0, 0, 0, 1,  -5, 1, 0,   0, 1, 0, 0};
    basic[5] = '{0, 0, 0, 1,  -5, 1, 0,   0, 1, 0, 0};
    basic[6] = '{0, 0, 0, 1,  -5, 1, 1, -15, 0, 1, 0};
    basic[7] = '{0, 0, 0, 0,   0, 1, 0,   0, 0, 0, 0};

    model_reset();
    done_count = 0;
    @(negedge clk_i);
    do_reset();

    // Basic group from the table
    for (int i = 0; i < 8; i++) begin
      step(basic[i].st, basic[i].np, basic[i].no, basic[i].v, basic[i].d, 0, basic[i].rdy);
      chk("tbl_out_valid", int'(out_valid_o), int'(basic[i].e_ov));
      chk("tbl_out_data", int'(out_data_o), basic[i].e_data);
      chk("tbl_busy", int'(busy_o), int'(basic[i].e_busy));
      chk("tbl_done", int'(done_o), int'(basic[i].e_done));
      chk("tbl_sat", int'(sat_o), int'(basic[i].e_sat));
      $display("vec %0d: in v=%0d d=%0d -> out_valid=%0d out_data=%0d busy=%0d done=%0d",
               i, basic[i].v, basic[i].d, out_valid_o, out_data_o, busy_o, done_o);
    end

    // Positive saturation, then negative saturation in a fresh group
    step(1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 30000, 0, 0);
    step(0, 0, 0, 1, 30000, 0, 0);
    chk("satp_data", int'(out_data_o), 32767);
    chk("satp_flag", int'(sat_o), 1);
    $display("sat+ : out_data=%0d sat=%0d", out_data_o, sat_o);
    step(1, 2, 1, 0, 0, 0, 1);
    chk("sat_clear", int'(sat_o), 0);
    step(0, 0, 0, 1, -30000, 0, 0);
    step(0, 0, 0, 1, -30000, 0, 0);
    chk("satn_data", int'(out_data_o), -32768);
    chk("satn_flag", int'(sat_o), 1);
    $display("sat- : out_data=%0d sat=%0d", out_data_o, sat_o);
    idle(1);
    chk("sat_drained", int'(out_valid_o), 0);

    // Full FIFO with backpressure: 8 accepted, 9 and 10 dropped, then resent
    popped.delete();
    done_count = 0;
    step(1, 1, 10, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, 1, i, 0, 0);
      if (i == 7) chk("bp_stall_7", int'(stall_o), 0);
      if (i == 8) chk("bp_stall_8", int'(stall_o), 1);
    end
    chk("bp_still_busy", int'(busy_o), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("bp_stall_fall", int'(stall_o), 0);
    for (int i = 0; i < 3; i++) idle(1);
    step(0, 0, 0, 1, 9, 0, 1);
    step(0, 0, 0, 1, 10, 0, 1);
    for (int i = 0; i < 8; i++) idle(1);
    for (int i = 1; i <= 10; i++) exp_seq.push_back(i);
    chk("bp_count", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++) chk("bp_order", popped[i], exp_seq[i]);
    chk("bp_done_once", done_count, 1);
    $display("backpressure: drained %0d results, done pulses=%0d", popped.size(), done_count);

    // Zero counts behave as one; valid in IDLE and start in ACCUM are ignored
    step(0, 0, 0, 1, 99, 0, 0);
    chk("idle_valid_busy", int'(busy_o), 0);
    chk("idle_valid_ov", int'(out_valid_o), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    chk("zero_data", int'(out_data_o), 7);
    chk("zero_done", int'(done_o), 1);
    $display("zero counts: out_data=%0d done=%0d", out_data_o, done_o);
    idle(1);
    step(1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0, 0);
    chk("ign_start_data", int'(out_data_o), 11);
    idle(1);

    // Carry-out is flagged but the data passes through untouched
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'sh1234, 1, 0);
    chk("carry_flag", int'(carry_o), 1);
    chk("carry_data", int'(out_data_o), 16'sh1234);
    $display("carry: carry=%0d out_data=%0d", carry_o, out_data_o);
    idle(1);

    // Reset in the middle of a group with results waiting
    step(1, 3, 10, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, i + 1, 0, 0);
    chk("mid_fifo", int'(out_valid_o), 1);
    do_reset();
    chk("mid_after_valid", int'(out_valid_o), 0);
    chk("mid_after_busy", int'(busy_o), 0);
    chk("mid_after_done", int'(done_o), 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 42, 0, 0);
    chk("mid_new_data", int'(out_data_o), 42);
    chk("mid_new_done", int'(done_o), 1);
    $display("reset mid-group: new group out_data=%0d done=%0d", out_data_o, done_o);
    idle(1);

    // Randomized groups against the model
    for (int g = 0; g < 25; g++) begin
      int np, no, d;
      np = $urandom_range(0, 5);
      no = $urandom_range(0, 12);
      step(1, np, no, 0, 0, 0, $urandom_range(0, 1));
      cyc = 0;
      while (m_busy && cyc < 3000) begin
        if ($urandom_range(0, 3) == 0) d = int'($signed(16'($urandom_range(0, 65535))));
        else d = $urandom_range(0, 200) - 100;
        step($urandom_range(0, 19) == 0, 1, 1, $urandom_range(0, 9) < 7, d,
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
        cyc++;
      end
      if (m_busy) chk("rand_group_timeout", cyc, -1);
      cyc = 0;
      while (q.size() > 0 && cyc < 20) begin
        idle(1);
        cyc++;
      end
      chk("rand_drain", q.size(), 0);
      $display("random group %0d: P=%0d N=%0d finished", g, np, no);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
